alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_skid_buf.sv | 79 +++++++
 rtl/alu_operand_stage.sv | 75 +++++++
 tb/tb_alu_operand_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage: op encodings,
// one-hot shifter selects, widths and the buffered operand payload.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRL = 2'b01;
  localparam logic [OP_W-1:0] OP_SRA = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL = 2'b11;

  localparam logic [SEL_W-1:0] SEL_SLL  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_SRL  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SRA  = 3'b100;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic               zero_force;
    logic [SEL_W-1:0]   sel;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  a;
  } operand_t;

  localparam int unsigned OPERAND_W = $bits(operand_t);

  function automatic logic [SEL_W-1:0] op_to_sel(input logic [OP_W-1:0] op);
    logic [SEL_W-1:0] sel;
    sel = SEL_NONE;
    case (op)
      OP_SLL:  sel = SEL_SLL;
      OP_SRL:  sel = SEL_SRL;
      OP_SRA:  sel = SEL_SRA;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer (main + skid register) with valid/ready handshake;
// ready and valid are registered, main register drives the payload output.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] data_o
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, valid_q;
  logic             push_c, pop_c;

  // Next-state and datapath steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    push_c  = push_i && ready_q;
    pop_c   = pop_ready_i && valid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push_c) begin
          main_d  = data_i;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        case ({push_c, pop_c})
          2'b10: begin
            skid_d  = data_i;
            state_d = SKID_FULL;
          end
          2'b01: state_d = SKID_EMPTY;
          2'b11: main_d  = data_i;
          default: ;
        endcase
      end
      SKID_FULL: begin
        if (pop_c) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != SKID_FULL);
      valid_q <= (state_d != SKID_EMPTY);
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = main_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Shift-operand stage: decodes op into a one-hot select, buffers operands in a
// skid buffer and counts illegal ops. Define ALU_SHAMT_SAT_EN for zero_force_o.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [OP_W-1:0]    op_i,
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  a_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               zero_force_o,
  output logic [CNT_W-1:0]   illegal_cnt_o
);

`ifdef ALU_SHAMT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  operand_t         in_op_c;
  operand_t         out_op;
  logic             ready;
  logic             accept_c, push_c, illegal_c;
  logic [CNT_W-1:0] cnt_q;

  // Large shift amounts only matter when saturation is enabled.
  always_comb begin
    in_op_c            = '0;
    in_op_c.a          = a_i;
    in_op_c.shamt      = b_i[SHAMT_W-1:0];
    in_op_c.sel        = op_to_sel(op_i);
    in_op_c.zero_force = SAT_EN & (|b_i[DATA_W-1:SHAMT_W]);
    accept_c           = in_valid_i && ready;
    push_c             = accept_c && (op_i != OP_ILL);
    illegal_c          = accept_c && (op_i == OP_ILL);
  end

  alu_skid_buf #(
    .WIDTH(OPERAND_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_c),
    .ready_o     (ready),
    .data_i      (in_op_c),
    .valid_o     (out_valid_o),
    .pop_ready_i (out_ready_i),
    .data_o      (out_op)
  );

  // Saturating illegal-op counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (illegal_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready_o    = ready;
  assign a_o           = out_op.a;
  assign shamt_o       = out_op.shamt;
  assign sel_o         = out_op.sel;
  assign zero_force_o  = out_op.zero_force;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage with a behavioural reference model.
// Honours ALU_SHAMT_SAT_EN for zero_force expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a_out;
  logic [4:0]  shamt_out;
  logic [2:0]  sel_out;
  logic        zf_out;
  logic [7:0]  cnt_out;

  int n_pass  = 0;
  int n_total = 0;

  alu_operand_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .a_o           (a_out),
    .shamt_o       (shamt_out),
    .sel_o         (sel_out),
    .zero_force_o  (zf_out),
    .illegal_cnt_o (cnt_out)
  );

  always #5 clk = ~clk;

  // Reference model of the operand rules.
  function automatic logic [2:0] ref_sel(input logic [1:0] o);
    return 3'(1 << o);
  endfunction

  function automatic logic [4:0] ref_shamt(input logic [31:0] v);
    return 5'(v % 32);
  endfunction

  function automatic logic ref_zf(input logic [31:0] v);
`ifdef ALU_SHAMT_SAT_EN
    return (v >= 32);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (cnt_out !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt_out); else n_pass++;
    n_total++; if ({a_out, shamt_out, sel_out, zf_out} !== 41'd0)
      $display("FAIL reset_data got=%h/%h/%b/%b exp=0", a_out, shamt_out, sel_out, zf_out); else n_pass++;
  endtask

  task automatic test_basic();
    op = 2'b00; a = 32'h1; b = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else n_pass++;
    n_total++; if (a_out !== 32'h1) $display("FAIL basic_a got=%h exp=1", a_out); else n_pass++;
    n_total++; if (shamt_out !== 5'd4) $display("FAIL basic_shamt got=%0d exp=4", shamt_out); else n_pass++;
    n_total++; if (sel_out !== 3'b001) $display("FAIL basic_sel got=%b exp=001", sel_out); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_drain got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] va[3];
    logic [31:0] vb[3];
    for (int i = 0; i < 3; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op = 2'(i); a = va[i]; b = vb[i]; in_valid = 1'b1;
      step();
      n_total++; if (in_ready !== (i == 0))
        $display("FAIL bp_in_ready_%0d got=%b exp=%b", i, in_ready, (i == 0)); else n_pass++;
      n_total++; if (a_out !== va[0] || out_valid !== 1'b1)
        $display("FAIL bp_hold_%0d got=%h/%b exp=%h/1", i, a_out, out_valid, va[0]); else n_pass++;
    end
    in_valid = 1'b0;
    n_total++; if (sel_out !== ref_sel(2'd0) || shamt_out !== ref_shamt(vb[0]))
      $display("FAIL bp_first_payload got=%b/%0d exp=%b/%0d", sel_out, shamt_out, ref_sel(2'd0), ref_shamt(vb[0])); else n_pass++;
    out_ready = 1'b1;
    step();
    n_total++; if (out_valid !== 1'b1 || a_out !== va[1] || sel_out !== ref_sel(2'd1))
      $display("FAIL bp_second got=%b/%h/%b exp=1/%h/%b", out_valid, a_out, sel_out, va[1], ref_sel(2'd1)); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_no_third got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_shamt();
    logic [31:0] va;
    va = $urandom;
    op = 2'b01; a = va; b = 32'h21; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++; if (shamt_out !== 5'd1) $display("FAIL shamt_mod got=%0d exp=1", shamt_out); else n_pass++;
    n_total++; if (zf_out !== ref_zf(32'h21)) $display("FAIL shamt_zf got=%b exp=%b", zf_out, ref_zf(32'h21)); else n_pass++;
    n_total++; if (sel_out !== 3'b010 || a_out !== va)
      $display("FAIL shamt_payload got=%b/%h exp=010/%h", sel_out, a_out, va); else n_pass++;
    step();
  endtask

  task automatic test_illegal();
    bit seen_valid = 0;
    bit lost_ready = 0;
    do_reset();
    op = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom; out_ready = 1'($urandom);
      step();
      if (out_valid) seen_valid = 1;
      if (!in_ready) lost_ready = 1;
      if (i == 9) begin
        n_total++; if (cnt_out !== 8'd10) $display("FAIL ill_cnt_10 got=%0d exp=10", cnt_out); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_total++; if (seen_valid !== 1'b0) $display("FAIL ill_out_valid got=%b exp=0", seen_valid); else n_pass++;
    n_total++; if (lost_ready !== 1'b0) $display("FAIL ill_in_ready got=%b exp=0", lost_ready); else n_pass++;
    n_total++; if (cnt_out !== 8'd255) $display("FAIL ill_cnt_sat got=%0d exp=255", cnt_out); else n_pass++;
  endtask

  task automatic test_reset_full();
    logic [31:0] vx;
    do_reset();
    op = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
    step();
    n_total++; if (cnt_out !== 8'd1) $display("FAIL rf_cnt_one got=%0d exp=1", cnt_out); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      op = 2'b10; a = $urandom; b = $urandom;
      step();
    end
    n_total++; if (in_ready !== 1'b0) $display("FAIL rf_full got=%b exp=0", in_ready); else n_pass++;
    rst = 1'b1; op = 2'b00; a = $urandom; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_out !== 8'd0 || a_out !== 32'd0)
      $display("FAIL rf_after_reset got=%b/%b/%0d/%h exp=0/1/0/0", out_valid, in_ready, cnt_out, a_out); else n_pass++;
    vx = $urandom;
    op = 2'b01; a = vx; b = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || a_out !== vx)
      $display("FAIL rf_push got=%b/%h exp=1/%h", out_valid, a_out, vx); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rf_alone got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_stream();
    logic [1:0]  eo[$];
    logic [31:0] ea[$];
    logic [31:0] eb[$];
    logic [1:0]  xo;
    logic [31:0] xa, xb;
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op = 2'($urandom_range(0, 2)); a = $urandom; b = $urandom; in_valid = 1'b1;
      eo.push_back(op); ea.push_back(a); eb.push_back(b);
      step();
      xo = eo.pop_front(); xa = ea.pop_front(); xb = eb.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || a_out !== xa || shamt_out !== ref_shamt(xb)
          || sel_out !== ref_sel(xo) || zf_out !== ref_zf(xb)) begin
        bad++;
        $display("FAIL stream_%0d got=%b/%b/%h/%0d/%b/%b exp=1/1/%h/%0d/%b/%b", i, out_valid, in_ready,
                 a_out, shamt_out, sel_out, zf_out, xa, ref_shamt(xb), ref_sel(xo), ref_zf(xb));
      end else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL stream_end got=%b exp=0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_shamt();
    test_illegal();
    test_reset_full();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
